// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader_pkg
//  Description : Shared types and constants for the program loader block.
//  Revision    : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

    // Payload bytes per program-memory word
    localparam int c_BYTES_PER_WORD = 4;

    // Loader controller states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN0    = 3'd1,
        LEN1    = 3'd2,
        PAYLOAD = 3'd3,
        CHECK   = 3'd4,
        FINISH  = 3'd5
    } loader_state_type;

    // Plain-vector encodings of the states, used by the state register
    localparam logic [2:0] c_ST_IDLE    = IDLE;
    localparam logic [2:0] c_ST_LEN0    = LEN0;
    localparam logic [2:0] c_ST_LEN1    = LEN1;
    localparam logic [2:0] c_ST_PAYLOAD = PAYLOAD;
    localparam logic [2:0] c_ST_CHECK   = CHECK;
    localparam logic [2:0] c_ST_FINISH  = FINISH;

endpackage
`default_nettype wire

// File: rtl/program_loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader_word_assembler
//  Description : Places incoming stream bytes into a little-endian 32-bit
//                word. o_word_valid pulses (combinationally) with the byte
//                that completes a word; o_word then carries the full word.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader_word_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_byte_cnt;
    logic [31:0] r_word;
    logic [31:0] w_word;

    // Each lane takes the incoming byte when the counter points at it
    for (genvar i = 0; i < c_BYTES_PER_WORD; i++) begin : g_lane
        localparam logic [1:0] c_LANE = 2'(i);
        assign w_word[8*i +: 8] = (i_byte_valid && (r_byte_cnt == c_LANE)) ?
                                  i_byte : r_word[8*i +: 8];
    end

    assign o_word       = w_word;
    assign o_word_valid = i_byte_valid && (r_byte_cnt == 2'd3);

    // Byte counter (wraps 3 -> 0) and the partially assembled word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_cnt <= 2'd0;
            r_word     <= 32'd0;
        end else if (i_clear) begin
            r_byte_cnt <= 2'd0;
            r_word     <= 32'd0;
        end else if (i_byte_valid) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_word     <= w_word;
        end
    end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Receives a length-prefixed byte stream, assembles
//                little-endian words and writes them into program memory
//                while holding the CPU pipeline in reset.
//                Optional build macro PROGRAM_LOADER_CHECKSUM_EN adds a
//                trailing XOR checksum byte after the payload.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MEM_WORDS  = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_enable,
    output logic [31:0]           mem_write_data,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  error
);

    localparam logic [15:0] c_MEM_WORDS = 16'(MEM_WORDS);

    logic [2:0]            r_state;
    logic                  r_in_ready;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic                  r_mem_we;
    logic [31:0]           r_mem_data;
    logic                  r_cpu_reset_n;
    logic                  r_busy;
    logic                  r_error;
    logic [15:0]           r_len;
    logic [15:0]           r_word_cnt;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]            r_checksum;
`endif

    logic                  w_xfer;
    logic                  w_start_load;
    logic                  w_word_valid;
    logic [31:0]           w_word;
    logic [15:0]           w_len_full;
    logic                  w_last_word;

    assign w_xfer       = in_valid && r_in_ready;
    assign w_start_load = (r_state == c_ST_IDLE) && start;
    assign w_len_full   = {in_data, r_len[7:0]};
    assign w_last_word  = (r_word_cnt == (r_len - 16'd1));

    program_loader_word_assembler u_word_assembler (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clear      (w_start_load),
        .i_byte_valid (w_xfer && (r_state == c_ST_PAYLOAD)),
        .i_byte       (in_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // Load controller: stream parsing, memory write strobe and CPU reset hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_ST_IDLE;
            r_in_ready    <= 1'b0;
            r_mem_address <= '0;
            r_mem_we      <= 1'b0;
            r_mem_data    <= 32'd0;
            r_cpu_reset_n <= 1'b0;
            r_busy        <= 1'b0;
            r_error       <= 1'b0;
            r_len         <= 16'd0;
            r_word_cnt    <= 16'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_checksum    <= 8'd0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // A failed load keeps the CPU in reset until a good one
                    r_cpu_reset_n <= ~r_error;
                    if (start) begin
                        r_state       <= c_ST_LEN0;
                        r_in_ready    <= 1'b1;
                        r_cpu_reset_n <= 1'b0;
                        r_busy        <= 1'b1;
                        r_error       <= 1'b0;
                        r_word_cnt    <= 16'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_checksum    <= 8'd0;
`endif
                    end
                end
                c_ST_LEN0: begin
                    if (w_xfer) begin
                        r_len[7:0] <= in_data;
                        r_state    <= c_ST_LEN1;
                    end
                end
                c_ST_LEN1: begin
                    if (w_xfer) begin
                        r_len[15:8] <= in_data;
                        if (w_len_full == 16'd0) begin
                            r_state    <= c_ST_FINISH;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state    <= c_ST_PAYLOAD;
                        end
                    end
                end
                c_ST_PAYLOAD: begin
                    if (w_xfer) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_checksum <= r_checksum ^ in_data;
`endif
                        if (w_word_valid) begin
                            // Words past the end of memory are consumed but not written
                            if (r_word_cnt >= c_MEM_WORDS) begin
                                r_error <= 1'b1;
                            end else begin
                                r_mem_we      <= 1'b1;
                                r_mem_data    <= w_word;
                                r_mem_address <= ADDR_WIDTH'({r_word_cnt, 2'b00});
                            end
                            r_word_cnt <= r_word_cnt + 16'd1;
                            if (w_last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                                r_state    <= c_ST_CHECK;
`else
                                r_state    <= c_ST_FINISH;
                                r_in_ready <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                c_ST_CHECK: begin
                    if (w_xfer) begin
                        if (in_data != r_checksum) begin
                            r_error <= 1'b1;
                        end
                        r_state    <= c_ST_FINISH;
                        r_in_ready <= 1'b0;
                    end
                end
`endif
                c_ST_FINISH: begin
                    r_busy        <= 1'b0;
                    r_cpu_reset_n <= ~r_error;
                    r_state       <= c_ST_IDLE;
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready         = r_in_ready;
    assign mem_address      = r_mem_address;
    assign mem_write_enable = r_mem_we;
    assign mem_write_data   = r_mem_data;
    assign cpu_reset_n      = r_cpu_reset_n;
    assign busy             = r_busy;
    assign error            = r_error;

endmodule
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder for the CPU's instruction memory. Accepts a byte stream over a valid/ready handshake and assembles it into little-endian 32-bit words.
- Writes those words through program_memory's write port: write_enable, write_data and byte address.
- Holds the CPU pipeline in reset while loading and releases it when the load completes.
- Sits beside program_memory and the CPU core. Drives the write port that the core ties off, and the core's reset_n.

Parameters:
- MEM_WORDS, 8, number of 32-bit words in program memory; words beyond this are discarded.
- ADDR_WIDTH, 5, width of the byte address driven to program_memory.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load when IDLE
- in_valid  in  1  byte available
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte this cycle
- mem_address  out  ADDR_WIDTH  byte address to program_memory (word index × 4)
- mem_write_enable  out  1  one-cycle write strobe
- mem_write_data  out  32  assembled word
- cpu_reset_n  out  1  active-low reset to CPU pipeline
- busy  out  1  load in progress
- error  out  1  sticky; overflow (or checksum mismatch), cleared on next start

Behaviour:
- Reset is asynchronous and active-low. While reset_n is low:
  - mem_write_enable, mem_address, mem_write_data, busy and error are 0.
  - cpu_reset_n is 0 and in_ready is 0.
  - State is IDLE.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×4 payload bytes, each word least-significant byte first.
- A byte transfers only on a cycle where in_valid && in_ready.
- All outputs are registered.
- State IDLE:
  - cpu_reset_n = 1 from the first clk edge after reset_n deasserts. in_ready = 0.
  - start → LEN0. On that edge: cpu_reset_n ← 0, busy ← 1, error ← 0, word counter ← 0, byte counter ← 0.
- State LEN0: in_ready = 1; transfer latches len[7:0] → LEN1.
- State LEN1: in_ready = 1; transfer latches len[15:8].
  - If N == 0 → FINISH.
  - Otherwise → PAYLOAD.
- State PAYLOAD: in_ready = 1; the 2-bit byte counter places each byte at [8k+7:8k].
- On the 4th byte of a word:
  - Next cycle: mem_write_enable = 1 for exactly one cycle, mem_write_data = word, mem_address = word_index×4 (truncated to ADDR_WIDTH).
  - in_ready stays 1 during the write cycle, so full-rate streaming gives one write per 4 cycles with no stall.
- Overflow: if word_index ≥ MEM_WORDS, the write strobe is suppressed and error ← 1. Remaining bytes are still consumed.
- After word N−1 is accepted → FINISH (or CHECK when the optional feature is compiled in).
- State FINISH:
  - Lasts one cycle, after the last write strobe has issued.
  - busy ← 0; cpu_reset_n ← 1 unless error; → IDLE.
  - If error is set, cpu_reset_n stays 0 until the next successful load.
- start while not IDLE is ignored.
- in_valid while in_ready = 0 is ignored; no byte is lost from the source's view, since no transfer occurs.
- Reset mid-load: the load is abandoned, all state is cleared, and partially written memory is left as-is.
- Byte counter wraps 3→0. Word counter is 16 bits and does not wrap within legal N.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the payload, state CHECK accepts one byte and compares it with the XOR of all payload bytes.
  - On mismatch, error ← 1 and the CPU stays in reset.
  - The length bytes are excluded from the XOR.
- Without the macro: no CHECK state, and the stream ends after the payload.

Decomposition:
- Shared package common:
  - loader_state_type enum: IDLE, LEN0, LEN1, PAYLOAD, CHECK, FINISH.
  - Constant BYTES_PER_WORD = 4.
- One natural sub-module, word_assembler: byte counter plus 32-bit shift/placement register, emitting word_valid with the completed word.

Test Plan:
- Reset then idle → cpu_reset_n 0 during reset, 1 the cycle after release; mem_write_enable never asserted.
- start; stream 02 00 13 05 10 00 93 05 20 00 at full rate:
  - writes 0x00100513 @ address 0, then 0x00200593 @ address 4, each strobe one cycle;
  - busy falls and cpu_reset_n rises after the second write.
- Same stream with in_valid toggling every other cycle → identical writes; no byte duplicated or dropped.
- N = 9 with MEM_WORDS = 8 → 8 writes (addresses 0–28), 9th suppressed, error = 1, cpu_reset_n held 0.
- start pulse asserted mid-load, then reset_n pulsed low mid-payload:
  - the start is ignored;
  - on reset, outputs return to reset values immediately (asynchronously); the next load works.
- With PROGRAM_LOADER_CHECKSUM_EN: payload 13 05 10 00 plus checksum 06 → success.
- With PROGRAM_LOADER_CHECKSUM_EN: payload 13 05 10 00 plus checksum 07 → error = 1, CPU held in reset.
